// File: rtl/data_cache_controller.sv
// data_cache_controller: direct-mapped write-back, write-allocate data cache with 16-byte lines.
// It uses a 128-bit block handshake to main memory, and the CPU stalls on BUSYWAIT while a miss is serviced.
module data_cache_controller #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   DATA_MEM_READ,
    input  logic [2:0]   DATA_MEM_WRITE,
    input  logic [31:0]  DATA_MEM_ADDR,
    input  logic [31:0]  DATA_MEM_WRITE_DATA,
    output logic [31:0]  DATA_MEM_READ_DATA,
    output logic         DATA_MEM_BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TW = 28 - INDEX_BITS;
    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, ALLOCATE} state_t;
    state_t r_state, w_next;
    logic [LINES-1:0] r_valid, r_dirty;
    logic [TW-1:0] r_tag [LINES];
    logic [127:0] r_data [LINES];
    logic [INDEX_BITS-1:0] r_idx;
    logic [TW-1:0] r_req_tag;
    logic [INDEX_BITS-1:0] w_index;
    logic [TW-1:0] w_tag;
    logic [1:0] w_word, w_wsz;
    logic w_wr, w_rd, w_req, w_hit, w_idle_hit, w_fill;
    logic [127:0] w_line;
    logic [31:0] w_rword, w_load, w_wrep, w_mword;
    logic [7:0] w_byte;
    logic [15:0] w_half;
    logic [3:0] w_be;
    logic [2:0] w_f3;
    assign w_index = DATA_MEM_ADDR[3+INDEX_BITS:4];
    assign w_tag = DATA_MEM_ADDR[31:4+INDEX_BITS];
    assign w_word = DATA_MEM_ADDR[3:2];
    assign w_wr = DATA_MEM_WRITE[2];
    assign w_rd = DATA_MEM_READ[3] & ~w_wr;
    assign w_req = w_wr | DATA_MEM_READ[3];
    assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_idle_hit = (r_state == IDLE) && w_hit;
    assign w_fill = (r_state == FETCH) && !MEM_BUSYWAIT;
    assign DATA_MEM_BUSYWAIT = !RESET && w_req && !w_idle_hit;
    assign w_line = r_data[w_index];
    assign w_rword = w_line[{w_word, 5'b0} +: 32];
    assign w_byte = w_rword[{DATA_MEM_ADDR[1:0], 3'b0} +: 8];
    assign w_half = DATA_MEM_ADDR[1] ? w_rword[31:16] : w_rword[15:0];
    assign w_f3 = DATA_MEM_READ[2:0];
    assign w_load = w_f3 == 3'b000 ? {{24{w_byte[7]}}, w_byte} :
                    w_f3 == 3'b001 ? {{16{w_half[15]}}, w_half} :
                    w_f3 == 3'b010 ? w_rword :
                    w_f3 == 3'b100 ? {24'b0, w_byte} :
                    w_f3 == 3'b101 ? {16'b0, w_half} : 32'b0;
    assign DATA_MEM_READ_DATA = (!RESET && w_rd && w_idle_hit) ? w_load : 32'b0;
    assign w_wsz = DATA_MEM_WRITE[1:0];
    assign w_be = w_wsz == 2'b00 ? 4'b0001 << DATA_MEM_ADDR[1:0] :
                  w_wsz == 2'b01 ? (DATA_MEM_ADDR[1] ? 4'b1100 : 4'b0011) :
                  w_wsz == 2'b10 ? 4'b1111 : 4'b0000;
    assign w_wrep = w_wsz == 2'b00 ? {4{DATA_MEM_WRITE_DATA[7:0]}} :
                    w_wsz == 2'b01 ? {2{DATA_MEM_WRITE_DATA[15:0]}} : DATA_MEM_WRITE_DATA;
    always_comb begin
        w_mword = w_rword;
        for (int b = 0; b < 4; b++)
            w_mword[b*8 +: 8] = w_be[b] ? w_wrep[b*8 +: 8] : w_rword[b*8 +: 8];
    end
    always_comb begin
        w_next = r_state;
        MEM_READ = 1'b0;
        MEM_WRITE = 1'b0;
        MEM_ADDRESS = '0;
        MEM_WRITEDATA = '0;
        unique case (r_state)
            IDLE: if (w_req && !w_hit)
                w_next = (r_valid[w_index] && r_dirty[w_index]) ? WRITEBACK : FETCH;
            WRITEBACK: begin
                MEM_WRITE = 1'b1;
                MEM_ADDRESS = {r_tag[r_idx], r_idx};
                MEM_WRITEDATA = r_data[r_idx];
                w_next = MEM_BUSYWAIT ? WRITEBACK : FETCH;
            end
            FETCH: begin
                MEM_READ = 1'b1;
                MEM_ADDRESS = {r_req_tag, r_idx};
                w_next = MEM_BUSYWAIT ? FETCH : ALLOCATE;
            end
            ALLOCATE: w_next = IDLE;
        endcase
    end
    // Miss target is latched in IDLE so later address changes cannot redirect an in-flight refill.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req && !w_hit) begin
                r_idx <= w_index;
                r_req_tag <= w_tag;
            end
            if (w_fill) begin
                r_valid[r_idx] <= 1'b1;
                r_dirty[r_idx] <= 1'b0;
                r_tag[r_idx] <= r_req_tag;
            end else if (w_wr && w_idle_hit) begin
                r_dirty[w_index] <= 1'b1;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (!RESET && w_fill)
            r_data[r_idx] <= MEM_READDATA;
        else if (!RESET && w_wr && w_idle_hit)
            r_data[w_index][{w_word, 5'b0} +: 32] <= w_mword;
    end
endmodule

// File: tb/tb_data_cache_controller.sv
// tb_data_cache_controller: vector table plus hand sequences against a latency-modelled block memory.
// Expected load data, fetch addresses and writeback blocks are queued and popped as the DUT produces them.
module tb_data_cache_controller;
    localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, LBU = 4'b1100, LHU = 4'b1101;
    localparam logic [2:0] SB = 3'b100, SH = 3'b101, SW = 3'b110;
    localparam int LAT = 3;
    logic CLK = 1'b0, RESET = 1'b1;
    logic [3:0] rd = '0;
    logic [2:0] wr = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] READ_DATA;
    logic BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [27:0] MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA, MEM_READDATA;
    data_cache_controller #(.INDEX_BITS(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .DATA_MEM_READ(rd), .DATA_MEM_WRITE(wr),
        .DATA_MEM_ADDR(addr), .DATA_MEM_WRITE_DATA(wdata),
        .DATA_MEM_READ_DATA(READ_DATA), .DATA_MEM_BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );
    always #5 CLK = ~CLK;
    int nchk = 0, nfail = 0;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [127:0] defblk(input logic [27:0] a);
        logic [31:0] b;
        b = {a, 4'h0};
        if (a == 28'h4) return {32'h4, 32'h3, 32'h2, 32'h1};
        return {b + 32'd12, b + 32'd8, b + 32'd4, b};
    endfunction
    bit [127:0] mem [256];
    bit wrt [256];
    int cnt = 0, cnt_nxt = 0, overlap = 0;
    typedef struct { logic [27:0] a; logic [127:0] d; } wb_t;
    wb_t exp_wb [$];
    logic [27:0] exp_fetch [$];
    logic [31:0] sb_q [$];
    assign MEM_READDATA = wrt[MEM_ADDRESS[7:0]] ? mem[MEM_ADDRESS[7:0]] : defblk(MEM_ADDRESS);
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < LAT - 1);
    always @(posedge CLK) cnt <= cnt_nxt;
    always @(negedge CLK) begin
        wb_t w;
        cnt_nxt = (!(MEM_READ || MEM_WRITE) || !MEM_BUSYWAIT) ? 0 : cnt + 1;
        if (MEM_READ && MEM_WRITE) overlap++;
        if (!RESET && MEM_WRITE && !MEM_BUSYWAIT) begin
            chk("wb_expected", exp_wb.size() != 0, 1);
            if (exp_wb.size() != 0) begin
                w = exp_wb.pop_front();
                chk("wb_addr", MEM_ADDRESS, w.a);
                chk("wb_data", MEM_WRITEDATA, w.d);
            end
            mem[MEM_ADDRESS[7:0]] = MEM_WRITEDATA;
            wrt[MEM_ADDRESS[7:0]] = 1'b1;
        end
        if (!RESET && MEM_READ && !MEM_BUSYWAIT) begin
            chk("fetch_expected", exp_fetch.size() != 0, 1);
            if (exp_fetch.size() != 0) chk("fetch_addr", MEM_ADDRESS, exp_fetch.pop_front());
        end
    end
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic do_req(input logic [3:0] r, input logic [2:0] w, input logic [31:0] a, d, ex,
                          input int es, input string nm);
        int st;
        rd = r; wr = w; addr = a; wdata = d;
        sb_q.push_back(ex);
        st = 0;
        #1;
        while (BUSYWAIT && st < 100) begin
            tick();
            st++;
        end
        chk({nm, "_stall"}, st, es);
        chk({nm, "_data"}, READ_DATA, sb_q.pop_front());
        tick();
        rd = '0; wr = '0;
    endtask
    typedef struct { logic [3:0] r; logic [2:0] w; logic [31:0] a, d, ex; } vec_t;
    vec_t tbl [14];
    initial begin
        int k;
        tbl[0]  = '{4'b0, SW, 32'h40, 32'h80FF7F01, 32'h0};
        tbl[1]  = '{LB,  3'b0, 32'h43, 32'h0, 32'hFFFFFF80};
        tbl[2]  = '{LBU, 3'b0, 32'h43, 32'h0, 32'h00000080};
        tbl[3]  = '{LH,  3'b0, 32'h42, 32'h0, 32'hFFFF80FF};
        tbl[4]  = '{LHU, 3'b0, 32'h40, 32'h0, 32'h00007F01};
        tbl[5]  = '{LH,  3'b0, 32'h41, 32'h0, 32'h00007F01};
        tbl[6]  = '{LHU, 3'b0, 32'h43, 32'h0, 32'h000080FF};
        tbl[7]  = '{LB,  3'b0, 32'h40, 32'h0, 32'h00000001};
        tbl[8]  = '{LW,  3'b0, 32'h43, 32'h0, 32'h80FF7F01};
        tbl[9]  = '{4'b0, SB, 32'h41, 32'h123456AB, 32'h0};
        tbl[10] = '{LW,  3'b0, 32'h40, 32'h0, 32'h80FFAB01};
        tbl[11] = '{4'b0, SH, 32'h46, 32'h5555CAFE, 32'h0};
        tbl[12] = '{LW,  3'b0, 32'h44, 32'h0, 32'hCAFE0002};
        tbl[13] = '{LBU, 3'b0, 32'h41, 32'h0, 32'h000000AB};
        rd = LW; addr = 32'h40;
        #1;
        chk("rst_busywait", BUSYWAIT, 0);
        chk("rst_read_data", READ_DATA, 0);
        tick();
        tick();
        chk("rst_mem_read", MEM_READ, 0);
        chk("rst_mem_write", MEM_WRITE, 0);
        RESET = 1'b0; rd = '0;
        tick();
        exp_fetch.push_back(28'h4);
        do_req(LW, 3'b0, 32'h40, 32'h0, 32'h1, 5, "lw40_miss");
        do_req(LW, 3'b0, 32'h44, 32'h0, 32'h2, 0, "lw44_hit");
        for (int i = 0; i < 14; i++)
            do_req(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ex, 0, $sformatf("vec%0d", i));
        exp_wb.push_back('{28'h4, {32'h4, 32'h3, 32'hCAFE0002, 32'h80FFAB01}});
        exp_fetch.push_back(28'hC);
        do_req(LW, 3'b0, 32'hC0, 32'h0, 32'hC0, 8, "dirty_evict");
        exp_fetch.push_back(28'h4);
        do_req(LW, 3'b0, 32'h44, 32'h0, 32'hCAFE0002, 5, "refetch_wb");
        exp_fetch.push_back(28'h20);
        do_req(4'b0, SW, 32'h200, 32'hDEADBEEF, 32'h0, 5, "sw_miss");
        do_req(LW, 3'b0, 32'h200, 32'h0, 32'hDEADBEEF, 0, "lw200_hit");
        exp_wb.push_back('{28'h20, {32'h20C, 32'h208, 32'h204, 32'hDEADBEEF}});
        exp_fetch.push_back(28'h30);
        do_req(LW, 3'b0, 32'h300, 32'h0, 32'h300, 8, "dirty_evict2");
        do_req(LW, SW, 32'h304, 32'h11112222, 32'h0, 0, "wr_priority");
        do_req(LW, 3'b0, 32'h304, 32'h0, 32'h11112222, 0, "wr_priority_rb");
        rd = LW; addr = 32'h1A0;
        k = 0;
        #1;
        while (!MEM_READ && k < 20) begin
            tick();
            k++;
        end
        chk("rstf_mem_read_pre", MEM_READ, 1);
        chk("rstf_addr", MEM_ADDRESS, 28'h1A);
        RESET = 1'b1;
        #1;
        chk("rstf_busywait", BUSYWAIT, 0);
        chk("rstf_read_data", READ_DATA, 0);
        tick();
        chk("rstf_mem_read", MEM_READ, 0);
        chk("rstf_mem_write", MEM_WRITE, 0);
        RESET = 1'b0; rd = '0;
        tick();
        exp_fetch.push_back(28'h30);
        do_req(LW, 3'b0, 32'h304, 32'h0, 32'h304, 5, "post_rst_miss");
        tick();
        chk("overlap_cycles", overlap, 0);
        chk("wb_left", exp_wb.size(), 0);
        chk("fetch_left", exp_fetch.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
